// File: rtl/video_pkg.sv
// Shared definitions for the video output stage: pixel modes and default geometry.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_BIN  = 2'd2,
    MODE_PAT  = 2'd3
  } mode_e;

  localparam int DW_DEF     = 8;
  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;

endpackage

// File: rtl/frame_geo_chk.sv
// Frame geometry checker: column/line/frame counters and sticky geo_err.
// Counter outputs for the test pattern exist only with VIDEO_OUT_PATTERN_EN.
module frame_geo_chk import video_pkg::*; #(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de,
  input  logic          boundary,
  input  logic          ch_switch,
`ifdef VIDEO_OUT_PATTERN_EN
  output logic [CW-1:0] col_cnt,
  output logic [CW-1:0] line_cnt,
`endif
  output logic [15:0]   frame_cnt,
  output logic          geo_err
);

  logic          de_prev_q, de_prev_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] line_q, line_d;
  logic [15:0]   frame_q, frame_d;
  logic          err_q, err_d;
  logic          armed_q, armed_d;
  logic          de_fall;

  always_comb begin
    de_prev_d = de;
    col_d     = col_q;
    line_d    = line_q;
    frame_d   = frame_q;
    err_d     = err_q;
    armed_d   = armed_q;
    de_fall   = de_prev_q & ~de;

    if (de) col_d = col_q + 1'b1;
    if (de_fall) begin
      col_d  = '0;
      line_d = line_q + 1'b1;
      if (col_q != CW'(H_DISP)) err_d = 1'b1;
    end

    // A line ending on the boundary cycle belongs to the new frame.
    if (boundary) begin
      if (armed_q && (frame_q != '0) && (line_q != CW'(V_DISP))) err_d = 1'b1;
      line_d  = de_fall ? CW'(1) : '0;
      frame_d = frame_q + 1'b1;
      armed_d = ~ch_switch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_prev_q <= 1'b0;
      col_q     <= '0;
      line_q    <= '0;
      frame_q   <= '0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      de_prev_q <= de_prev_d;
      col_q     <= col_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

`ifdef VIDEO_OUT_PATTERN_EN
  assign col_cnt  = col_q;
  assign line_cnt = line_q;
`endif
  assign frame_cnt = frame_q;
  assign geo_err   = err_q;

endmodule

// File: rtl/video_out_sel.sv
// Output stage: per-frame stream select + pixel mode, grey-to-RGB, geometry check.
// Mode 3 is a col^line test pattern with VIDEO_OUT_PATTERN_EN, else white.
module video_out_sel import video_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int N_CH   = 3,
  parameter int SW     = 2,
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    ch_de,
  input  logic [N_CH-1:0]    ch_hsync,
  input  logic [N_CH-1:0]    ch_vsync,
  input  logic [N_CH*DW-1:0] ch_data,
  input  logic [SW-1:0]      sel_in,
  input  logic [1:0]         mode_in,
  input  logic [DW-1:0]      thresh_in,
  output logic               VGA_hsync,
  output logic               VGA_vsync,
  output logic               VGA_de,
  output logic [3*DW-1:0]    VGA_data,
  output logic [SW-1:0]      sel_active,
  output logic [15:0]        frame_cnt,
  output logic               geo_err
);

  logic [SW-1:0]   sel_q, sel_d;
  mode_e           mode_q, mode_d;
  logic [DW-1:0]   thresh_q, thresh_d;
  logic            vs_prev_q, vs_prev_d;
  logic            boundary, ch_switch;

  logic            s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic [DW-1:0]   s1_data_q, s1_data_d, s1_thresh_q, s1_thresh_d;
  mode_e           s1_mode_q, s1_mode_d;

  logic            vga_de_q, vga_de_d, vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
  logic [3*DW-1:0] vga_data_q, vga_data_d;
  logic [DW-1:0]   g;

`ifdef VIDEO_OUT_PATTERN_EN
  logic [15:0]     col_cnt, line_cnt;
  logic [DW-1:0]   s1_pat_q, s1_pat_d;
`endif

  always_comb begin
    sel_d    = sel_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    boundary = ch_vsync[sel_q] & ~vs_prev_q;
    if (boundary) begin
      if (int'(sel_in) < N_CH) sel_d = sel_in;
      mode_d   = mode_e'(mode_in);
      thresh_d = thresh_in;
    end
    ch_switch = boundary && (sel_d != sel_q);
    // Track the channel that will be active next so a switch cannot fake an edge.
    vs_prev_d = ch_vsync[sel_d];

    s1_de_d     = ch_de[sel_q];
    s1_hs_d     = ch_hsync[sel_q];
    s1_vs_d     = ch_vsync[sel_q];
    s1_data_d   = ch_data[int'(sel_q)*DW +: DW];
    s1_mode_d   = mode_q;
    s1_thresh_d = thresh_q;
`ifdef VIDEO_OUT_PATTERN_EN
    s1_pat_d    = col_cnt[DW-1:0] ^ line_cnt[DW-1:0];
`endif
  end

  always_comb begin
    g = s1_data_q;
    case (s1_mode_q)
      MODE_PASS: g = s1_data_q;
      MODE_INV:  g = ~s1_data_q;
      MODE_BIN:  g = (s1_data_q >= s1_thresh_q) ? '1 : '0;
`ifdef VIDEO_OUT_PATTERN_EN
      MODE_PAT:  g = s1_pat_q;
`else
      MODE_PAT:  g = '1;
`endif
    endcase
    vga_de_d   = s1_de_q;
    vga_hs_d   = s1_hs_q;
    vga_vs_d   = s1_vs_q;
    vga_data_d = s1_de_q ? {3{g}} : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= '0;
      mode_q      <= MODE_PASS;
      thresh_q    <= '0;
      vs_prev_q   <= 1'b0;
      s1_de_q     <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= MODE_PASS;
      s1_thresh_q <= '0;
`ifdef VIDEO_OUT_PATTERN_EN
      s1_pat_q    <= '0;
`endif
      vga_de_q    <= 1'b0;
      vga_hs_q    <= 1'b0;
      vga_vs_q    <= 1'b0;
      vga_data_q  <= '0;
    end else begin
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      thresh_q    <= thresh_d;
      vs_prev_q   <= vs_prev_d;
      s1_de_q     <= s1_de_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      s1_thresh_q <= s1_thresh_d;
`ifdef VIDEO_OUT_PATTERN_EN
      s1_pat_q    <= s1_pat_d;
`endif
      vga_de_q    <= vga_de_d;
      vga_hs_q    <= vga_hs_d;
      vga_vs_q    <= vga_vs_d;
      vga_data_q  <= vga_data_d;
    end
  end

  frame_geo_chk #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP),
    .CW     (16)
  ) u_geo (
    .clk       (clk),
    .rst       (rst),
    .de        (ch_de[sel_q]),
    .boundary  (boundary),
    .ch_switch (ch_switch),
`ifdef VIDEO_OUT_PATTERN_EN
    .col_cnt   (col_cnt),
    .line_cnt  (line_cnt),
`endif
    .frame_cnt (frame_cnt),
    .geo_err   (geo_err)
  );

  assign VGA_de     = vga_de_q;
  assign VGA_hsync  = vga_hs_q;
  assign VGA_vsync  = vga_vs_q;
  assign VGA_data   = vga_data_q;
  assign sel_active = sel_q;

endmodule

// File: tb/tb_video_out_sel.sv
// Directed bench for video_out_sel on 8x4 frames, three channels.
// Mode-3 expectation follows VIDEO_OUT_PATTERN_EN.
module tb_video_out_sel;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ch_de, ch_hsync, ch_vsync;
  logic [23:0] ch_data;
  logic [1:0]  sel_in, mode_in;
  logic [7:0]  thresh_in;
  logic        VGA_hsync, VGA_vsync, VGA_de;
  logic [23:0] VGA_data;
  logic [1:0]  sel_active;
  logic [15:0] frame_cnt;
  logic        geo_err;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef VIDEO_OUT_PATTERN_EN
  localparam logic [23:0] PAT_EXP = 24'h030303;
`else
  localparam logic [23:0] PAT_EXP = 24'hFFFFFF;
`endif

  always #5 clk = ~clk;

  video_out_sel #(
    .DW     (8),
    .N_CH   (3),
    .SW     (2),
    .H_DISP (8),
    .V_DISP (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_de      (ch_de),
    .ch_hsync   (ch_hsync),
    .ch_vsync   (ch_vsync),
    .ch_data    (ch_data),
    .sel_in     (sel_in),
    .mode_in    (mode_in),
    .thresh_in  (thresh_in),
    .VGA_hsync  (VGA_hsync),
    .VGA_vsync  (VGA_vsync),
    .VGA_de     (VGA_de),
    .VGA_data   (VGA_data),
    .sel_active (sel_active),
    .frame_cnt  (frame_cnt),
    .geo_err    (geo_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick_vs(input logic [2:0] v);
    ch_de    = '0;
    ch_hsync = '0;
    ch_vsync = v;
    tick();
  endtask

  task automatic vs_pulse();
    tick_vs(3'b111);
    tick_vs(3'b000);
  endtask

  // ch0 = 0x11, ch2 = 0x22 constant; ch1 = da before index split, db after.
  task automatic line(input int npix, input logic [7:0] da, input logic [7:0] db,
                      input int split, input int cidx, input logic [23:0] cexp,
                      input string tag);
    logic [7:0] d1;
    for (int j = 0; j < npix + 3; j++) begin
      ch_de    = (j < npix) ? 3'b111 : 3'b000;
      ch_hsync = (j == npix + 1) ? 3'b111 : 3'b000;
      ch_vsync = '0;
      d1       = (j < split) ? da : db;
      ch_data  = {8'h22, d1, 8'h11};
      tick();
      if (cidx >= 0 && j == cidx + 1) begin
        chk(tag, VGA_data, cexp);
        chk({tag, "_de"}, {23'd0, VGA_de}, 24'd1);
      end
    end
    chk({tag, "_blank"}, VGA_data, 24'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  VGA_data, 24'd0);
    chk({tag, "_de"},    {23'd0, VGA_de}, 24'd0);
    chk({tag, "_hs"},    {23'd0, VGA_hsync}, 24'd0);
    chk({tag, "_vs"},    {23'd0, VGA_vsync}, 24'd0);
    chk({tag, "_sel"},   {22'd0, sel_active}, 24'd0);
    chk({tag, "_frame"}, {8'd0, frame_cnt}, 24'd0);
    chk({tag, "_geo"},   {23'd0, geo_err}, 24'd0);
  endtask

  initial begin
    rst = 1'b1;
    ch_de = '0; ch_hsync = '0; ch_vsync = '0; ch_data = '0;
    sel_in = '0; mode_in = '0; thresh_in = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Pass mode on channel 1
    sel_in = 2'd1; mode_in = 2'd0;
    vs_pulse();
    chk("t1_sel", {22'd0, sel_active}, 24'd1);
    chk("t1_frame1", {8'd0, frame_cnt}, 24'd1);
    line(8, 8'h5A, 8'h5A, 8, 0, 24'h5A5A5A, "t1_pass");
    repeat (3) line(8, 8'h5A, 8'h5A, 8, -1, 24'd0, "t1_line");
    vs_pulse();
    chk("t1_frame2", {8'd0, frame_cnt}, 24'd2);
    chk("t1_geo", {23'd0, geo_err}, 24'd0);

    // Mid-frame select request is held until the next ch1 vsync rise
    line(8, 8'h5A, 8'h5A, 8, 0, 24'h5A5A5A, "t2_pre");
    sel_in = 2'd2;
    line(8, 8'h5A, 8'h5A, 8, 0, 24'h5A5A5A, "t2_hold");
    chk("t2_sel_hold", {22'd0, sel_active}, 24'd1);
    repeat (2) line(8, 8'h5A, 8'h5A, 8, -1, 24'd0, "t2_line");
    tick_vs(3'b100);
    chk("t2_ch2_lead", {8'd0, frame_cnt}, 24'd2);
    tick_vs(3'b110);
    chk("t2_sel_sw", {22'd0, sel_active}, 24'd2);
    chk("t2_frame3", {8'd0, frame_cnt}, 24'd3);
    tick_vs(3'b110);
    chk("t2_nofalse", {8'd0, frame_cnt}, 24'd3);
    tick_vs(3'b000);
    line(8, 8'h5A, 8'h5A, 8, 0, 24'h222222, "t2_ch2");
    repeat (3) line(8, 8'h5A, 8'h5A, 8, -1, 24'd0, "t2_line");

    // Binarise at 0x80 on channel 1
    sel_in = 2'd1; mode_in = 2'd2; thresh_in = 8'h80;
    vs_pulse();
    chk("t3_frame4", {8'd0, frame_cnt}, 24'd4);
    line(8, 8'h7F, 8'h80, 4, 3, 24'h000000, "t3_bin_lo");
    line(8, 8'h7F, 8'h80, 4, 4, 24'hFFFFFF, "t3_bin_hi");
    repeat (2) line(8, 8'h7F, 8'h7F, 8, -1, 24'd0, "t3_line");

    // Out-of-range select keeps channel, mode still moves to invert
    sel_in = 2'd3; mode_in = 2'd1;
    vs_pulse();
    chk("t4_sel_keep", {22'd0, sel_active}, 24'd1);
    chk("t4_frame5", {8'd0, frame_cnt}, 24'd5);
    line(8, 8'h00, 8'h00, 8, 0, 24'hFFFFFF, "t3_inv");
    chk("t5_geo_pre", {23'd0, geo_err}, 24'd0);
    line(7, 8'h00, 8'h00, 7, -1, 24'd0, "t5_short");
    chk("t5_geo_short", {23'd0, geo_err}, 24'd1);
    line(8, 8'h00, 8'h00, 8, -1, 24'd0, "t5_line");
    chk("t5_geo_sticky", {23'd0, geo_err}, 24'd1);

    // Asynchronous reset in the middle of a line
    ch_de = 3'b111; ch_data = 24'h220011;
    repeat (3) tick();
    chk("t6_pre_rst", VGA_data, 24'hFFFFFF);
    rst = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    tick();
    ch_de = '0;
    rst = 1'b0;
    tick();

    // Mode 3, then a 3-line frame after an exempt first frame
    sel_in = 2'd1; mode_in = 2'd3;
    vs_pulse();
    chk("t6_frame1", {8'd0, frame_cnt}, 24'd1);
    line(8, 8'h5A, 8'h5A, 8, -1, 24'd0, "t6_line");
    line(8, 8'h5A, 8'h5A, 8, 2, PAT_EXP, "t6_pattern");
    repeat (2) line(8, 8'h5A, 8'h5A, 8, -1, 24'd0, "t6_line");
    vs_pulse();
    chk("t6_frame2", {8'd0, frame_cnt}, 24'd2);
    chk("t5_geo_4lines", {23'd0, geo_err}, 24'd0);
    repeat (3) line(8, 8'h5A, 8'h5A, 8, -1, 24'd0, "t5_line3");
    chk("t5_geo_before", {23'd0, geo_err}, 24'd0);
    vs_pulse();
    chk("t5_geo_3lines", {23'd0, geo_err}, 24'd1);
    chk("t5_frame3", {8'd0, frame_cnt}, 24'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
